ct_idu_dep_vreg_alloc_ctrl: RTL and testbench

- Allocation controller for the IDU vector-register dependency entry array.
- Grants up to two in-order create requests per cycle to free entries and drives each entry's per-entry write enables and gated-clock enables.
- Tracks entry occupancy, releases entries on issue, and clears all entries on front-end or issue flush.
- Sits between decode/dispatch create logic and the per-entry dependency storage.

---
 rtl/ct_idu_dep_vreg_alloc_ctrl.sv | 136 +++++++++++++
 tb/tb_ct_idu_dep_vreg_alloc_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ct_idu_dep_vreg_alloc_ctrl.sv
// Allocation control for the IDU vector-register dependency entries:
// dual in-order create grant, issue release, flush clear and clock gating.

module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic en_bf_latch;
  logic en_af_latch;

  assign en_bf_latch = (global_en & (module_en | local_en))
                     | external_en;

  // Transparent while the clock is low so the enable is glitch-free.
  always_latch begin
    if (!clk_in)
      en_af_latch = en_bf_latch;
  end

  assign clk_out = clk_in & (en_af_latch | pad_yy_icg_scan_en);

endmodule

module ct_idu_dep_vreg_alloc_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 cp0_idu_icg_en,
  input  logic                 cp0_yy_clk_en,
  input  logic                 pad_yy_icg_scan_en,
  input  logic                 rtu_idu_flush_fe,
  input  logic                 rtu_idu_flush_is,
  input  logic                 create0_req,
  input  logic                 create1_req,
  input  logic [ENTRY_NUM-1:0] release_vec,
  output logic                 create0_gnt,
  output logic                 create1_gnt,
  output logic [ENTRY_NUM-1:0] create0_idx,
  output logic [ENTRY_NUM-1:0] create1_idx,
  output logic [ENTRY_NUM-1:0] x_write_en,
  output logic [ENTRY_NUM-1:0] x_gateclk_write_en,
  output logic                 gateclk_entry_vld,
  output logic [ENTRY_NUM-1:0] entry_vld,
  output logic [CNT_W-1:0]     occ_cnt,
  output logic                 full,
  output logic                 almost_full
);

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [ENTRY_NUM-1:0] v
  );
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      s = s + CNT_W'(v[i]);
    return s;
  endfunction

  logic                 flush;
  logic                 local_en;
  logic                 entry_clk;
  logic [ENTRY_NUM-1:0] free;
  logic [ENTRY_NUM-1:0] lo_free;
  logic [ENTRY_NUM-1:0] hi_free;
  logic                 two_free;
  logic [ENTRY_NUM-1:0] vld_next;
  logic [CNT_W-1:0]     cnt_next;

  assign flush    = rtu_idu_flush_fe | rtu_idu_flush_is;
  assign local_en = flush | create0_req | (|release_vec);

  gated_clk_cell u_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_idu_icg_en),
    .local_en           (local_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (entry_clk)
  );

  assign free     = ~entry_vld;
  assign lo_free  = free & (~free + 1'b1);
  // At least two free bits means lowest and highest differ.
  assign two_free = |(free & (free - 1'b1));

  always_comb begin
    hi_free = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (free[i]) begin
        hi_free    = '0;
        hi_free[i] = 1'b1;
      end
    end
  end

  assign create0_gnt = ~flush & create0_req & (|free);
  assign create1_gnt = ~flush & create1_req & create0_gnt & two_free;
  assign create0_idx = create0_gnt ? lo_free : '0;
  assign create1_idx = create1_gnt ? hi_free : '0;

  assign x_write_en         = create0_idx | create1_idx;
  assign x_gateclk_write_en = x_write_en;
  assign gateclk_entry_vld  = |entry_vld;

  assign vld_next = (entry_vld & ~release_vec) | x_write_en;
  assign cnt_next = occ_cnt
                  - popcnt(release_vec & entry_vld)
                  + CNT_W'(create0_gnt)
                  + CNT_W'(create1_gnt);

  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      entry_vld <= '0;
      occ_cnt   <= '0;
    end else if (flush) begin
      entry_vld <= '0;
      occ_cnt   <= '0;
    end else begin
      entry_vld <= vld_next;
      occ_cnt   <= cnt_next;
    end
  end

  assign full        = (occ_cnt == CNT_W'(ENTRY_NUM));
  assign almost_full = (occ_cnt == CNT_W'(ENTRY_NUM - 1));

endmodule

// File: tb/tb_ct_idu_dep_vreg_alloc_ctrl.sv
// Directed bench for the dependency-entry allocation controller.

module tb_ct_idu_dep_vreg_alloc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       icg_en;
  logic       clk_en;
  logic       scan_en;
  logic       fl_fe;
  logic       fl_is;
  logic       c0;
  logic       c1;
  logic [7:0] rel;
  logic       g0;
  logic       g1;
  logic [7:0] i0;
  logic [7:0] i1;
  logic [7:0] xw;
  logic [7:0] xgw;
  logic       gvld;
  logic [7:0] vld;
  logic [3:0] cnt;
  logic       full;
  logic       afull;

  int checks;
  int errors;

  ct_idu_dep_vreg_alloc_ctrl #(.ENTRY_NUM(8), .CNT_W(4)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_idu_icg_en     (icg_en),
    .cp0_yy_clk_en      (clk_en),
    .pad_yy_icg_scan_en (scan_en),
    .rtu_idu_flush_fe   (fl_fe),
    .rtu_idu_flush_is   (fl_is),
    .create0_req        (c0),
    .create1_req        (c1),
    .release_vec        (rel),
    .create0_gnt        (g0),
    .create1_gnt        (g1),
    .create0_idx        (i0),
    .create1_idx        (i1),
    .x_write_en         (xw),
    .x_gateclk_write_en (xgw),
    .gateclk_entry_vld  (gvld),
    .entry_vld          (vld),
    .occ_cnt            (cnt),
    .full               (full),
    .almost_full        (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a0, input logic a1,
                       input logic fe, input logic is_,
                       input logic [7:0] r);
    c0 = a0; c1 = a1; fl_fe = fe; fl_is = is_; rel = r;
    #1;
  endtask

  task automatic chk_comb(input string tag,
                          input logic e0, input logic e1,
                          input logic [7:0] ei0,
                          input logic [7:0] ei1);
    chk({tag, "_g0"}, 32'(g0), 32'(e0));
    chk({tag, "_g1"}, 32'(g1), 32'(e1));
    chk({tag, "_i0"}, 32'(i0), 32'(ei0));
    chk({tag, "_i1"}, 32'(i1), 32'(ei1));
    chk({tag, "_xw"}, 32'(xw), 32'(ei0 | ei1));
    chk({tag, "_xgw"}, 32'(xgw), 32'(ei0 | ei1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag,
                           input logic [7:0] ev,
                           input logic [3:0] ec,
                           input logic ef, input logic eaf);
    chk({tag, "_vld"}, 32'(vld), 32'(ev));
    chk({tag, "_cnt"}, 32'(cnt), 32'(ec));
    chk({tag, "_full"}, 32'(full), 32'(ef));
    chk({tag, "_afull"}, 32'(afull), 32'(eaf));
    chk({tag, "_gvld"}, 32'(gvld), 32'(ev != 8'h00));
    chk({tag, "_inv"}, 32'(cnt), 32'($countones(vld)));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    icg_en = 1'b0;
    clk_en = 1'b1;
    scan_en = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    chk_comb("rst", 0, 0, 8'h00, 8'h00);
    chk_state("rst", 8'h00, 4'd0, 0, 0);
    #6 rst_n = 1'b1;
    tick();

    drive(1, 0, 0, 0, 8'h00);
    chk_comb("c0only", 1, 0, 8'h01, 8'h00);
    tick();
    chk_state("c0only", 8'h01, 4'd1, 0, 0);

    drive(1, 0, 1, 0, 8'h01);
    chk_comb("flfe", 0, 0, 8'h00, 8'h00);
    tick();
    chk_state("flfe", 8'h00, 4'd0, 0, 0);

    drive(1, 1, 0, 0, 8'h00);
    chk_comb("both_a", 1, 1, 8'h01, 8'h80);
    tick();
    chk_state("both_a", 8'h81, 4'd2, 0, 0);

    drive(1, 1, 0, 0, 8'h00);
    chk_comb("both_b", 1, 1, 8'h02, 8'h40);
    tick();
    chk_state("both_b", 8'hC3, 4'd4, 0, 0);

    drive(1, 1, 0, 0, 8'h00);
    chk_comb("both_c", 1, 1, 8'h04, 8'h20);
    tick();
    chk_state("both_c", 8'hE7, 4'd6, 0, 0);

    drive(1, 0, 0, 0, 8'h00);
    chk_comb("fill7", 1, 0, 8'h08, 8'h00);
    tick();
    chk_state("fill7", 8'hEF, 4'd7, 0, 1);

    drive(1, 1, 0, 0, 8'h00);
    chk_comb("lastone", 1, 0, 8'h10, 8'h00);
    tick();
    chk_state("lastone", 8'hFF, 4'd8, 1, 0);

    drive(1, 1, 0, 0, 8'h00);
    chk_comb("fullreq", 0, 0, 8'h00, 8'h00);

    drive(1, 0, 0, 0, 8'h04);
    chk_comb("relcr", 0, 0, 8'h00, 8'h00);
    tick();
    chk_state("relcr", 8'hFB, 4'd7, 0, 1);

    drive(1, 0, 0, 0, 8'h00);
    chk_comb("regrant", 1, 0, 8'h04, 8'h00);
    tick();
    chk_state("regrant", 8'hFF, 4'd8, 1, 0);

    drive(0, 0, 0, 0, 8'h07);
    tick();
    chk_state("to5", 8'hF8, 4'd5, 0, 0);

    drive(1, 1, 0, 1, 8'h08);
    chk_comb("flis", 0, 0, 8'h00, 8'h00);
    tick();
    chk_state("flis", 8'h00, 4'd0, 0, 0);

    drive(0, 1, 0, 0, 8'h00);
    chk_comb("c1only", 0, 0, 8'h00, 8'h00);
    tick();
    chk_state("c1only", 8'h00, 4'd0, 0, 0);

    drive(1, 0, 0, 0, 8'h00);
    tick();
    chk_state("one", 8'h01, 4'd1, 0, 0);

    drive(0, 0, 0, 0, 8'h40);
    tick();
    chk_state("relinv", 8'h01, 4'd1, 0, 0);

    drive(1, 1, 0, 0, 8'h00);
    tick();
    chk_state("pre_rst", 8'h83, 4'd3, 0, 0);
    drive(0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk_state("midrst", 8'h00, 4'd0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_state("postrst", 8'h00, 4'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
